// File: rtl/slow_clk_serializer_if.sv
// slow_clk_serializer_if: valid/ready word handshake feeding the serializer.
// master drives words, slave (the serializer) returns ready.
interface slow_clk_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/slow_clk_serializer.sv
// slow_clk_serializer: MSB-first serializer on clk_in, bits advance on slow_clk falls.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module slow_clk_serializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 slow_clk,
  slow_clk_serializer_if.slave tx,
  output logic                 ser_clk,
  output logic                 ser_data,
  output logic                 ser_frame,
  output logic                 busy,
  output logic                 underrun
);

`ifdef SER_PARITY_EN
  localparam int CNT_MAX = DATA_WIDTH;
`else
  localparam int CNT_MAX = DATA_WIDTH - 1;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ser_clk_q;
  logic [DATA_WIDTH-1:0]  buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   frame_q, frame_d;
  logic                   busy_q, busy_d;
  logic                   under_q, under_d;
  logic                   s, fall, accept, load;
`ifdef SER_PARITY_EN
  logic                   par_q, par_d;
`endif

  assign s           = sync_q[SYNC_STAGES-1];
  assign fall        = ~s & ser_clk_q;
  assign tx.tx_ready = ~buf_full_q;
  assign accept      = tx.tx_valid & ~buf_full_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    frame_d    = frame_q;
    under_d    = 1'b0;
    load       = 1'b0;
`ifdef SER_PARITY_EN
    par_d      = par_q;
`endif
    if (fall) begin
      unique case (state_q)
        IDLE: load = buf_full_q;
        SHIFT: begin
          if (cnt_q != '0) begin
            data_d  = shift_q[DATA_WIDTH-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CW'(1);
            frame_d = 1'b0;
`ifdef SER_PARITY_EN
            if (cnt_q == CW'(1)) data_d = par_q;
`endif
          end else if (buf_full_q) begin
            load = 1'b1;
          end else begin
            data_d  = 1'b0;
            frame_d = 1'b0;
            under_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
    // shift_q holds the bits still to go, MSB already on ser_data
    if (load) begin
      shift_d    = buf_q << 1;
      buf_full_d = 1'b0;
      data_d     = buf_q[DATA_WIDTH-1];
      frame_d    = 1'b1;
      cnt_d      = CW'(CNT_MAX);
      state_d    = SHIFT;
`ifdef SER_PARITY_EN
      par_d      = ^buf_q;
`endif
    end
    if (accept) begin
      buf_d      = tx.tx_data;
      buf_full_d = 1'b1;
    end
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      ser_clk_q  <= 1'b0;
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      data_q     <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
      under_q    <= 1'b0;
`ifdef SER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      ser_clk_q  <= s;
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      under_q    <= under_d;
`ifdef SER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign ser_clk   = ser_clk_q;
  assign ser_data  = data_q;
  assign ser_frame = frame_q;
  assign busy      = busy_q;
  assign underrun  = under_q;

endmodule

// File: tb/tb_slow_clk_serializer.sv
// tb_slow_clk_serializer: bit-queue model of the serializer checked every cycle,
// plus literal frame contents recovered at ser_clk rising edges.
`timescale 1ns/1ps
module tb_slow_clk_serializer;
  localparam int DW   = 16;
  localparam int SS   = 2;
  localparam int HALF = 195;
  localparam int BUDGET = 20000;
`ifdef SER_PARITY_EN
  localparam int FLEN = DW + 1;
`else
  localparam int FLEN = DW;
`endif

  logic clk_in   = 1'b0;
  logic reset_n  = 1'b0;
  logic slow_clk = 1'b0;
  logic ser_clk, ser_data, ser_frame, busy, underrun;

  slow_clk_serializer_if #(.DATA_WIDTH(DW)) tx();

  slow_clk_serializer #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .slow_clk (slow_clk),
    .tx       (tx),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .ser_frame(ser_frame),
    .busy     (busy),
    .underrun (underrun)
  );

  always #20 clk_in = ~clk_in;

  // 64 kHz from 25 MHz: one slow edge every HALF system cycles
  initial begin
    forever begin
      repeat (HALF) @(negedge clk_in);
      #2 slow_clk = ~slow_clk;
    end
  end

  int total = 0;
  int bad   = 0;
  int ucnt  = 0;
  logic [1:0] rx[$];

  // model: slow_clk history, one-word buffer, queue of bits still to send
  logic [SS+1:0] h;
  logic m_full, m_data, m_frame, m_busy, m_under, m_sc;
  logic m_acc, m_fall;
  logic [DW-1:0] m_word;
  bit m_bits[$];
  logic prev_sc;
  logic [5:0] got, want;

  always @(negedge clk_in) begin
    if (!reset_n) begin
      h = '0;
      m_full = 1'b0; m_data = 1'b0; m_frame = 1'b0;
      m_busy = 1'b0; m_under = 1'b0; m_sc = 1'b0;
      m_word = '0;
      m_bits.delete();
    end else begin
      h = {h[SS:0], slow_clk};
      m_fall = !h[SS] && h[SS+1];
      m_acc = tx.tx_valid && !m_full;
      m_under = 1'b0;
      if (m_fall) begin
        if (m_bits.size() > 0) begin
          m_data = m_bits.pop_front();
          m_frame = 1'b0;
        end else if (m_full) begin
          for (int i = DW - 1; i >= 0; i--) m_bits.push_back(m_word[i]);
`ifdef SER_PARITY_EN
          m_bits.push_back(^m_word);
`endif
          m_data = m_bits.pop_front();
          m_frame = 1'b1;
          m_busy = 1'b1;
          m_full = 1'b0;
        end else if (m_busy) begin
          m_data = 1'b0;
          m_frame = 1'b0;
          m_busy = 1'b0;
          m_under = 1'b1;
        end
      end
      if (m_acc) begin
        m_full = 1'b1;
        m_word = tx.tx_data;
      end
      m_sc = h[SS];
    end
    got  = {tx.tx_ready, ser_clk, ser_data, ser_frame, busy, underrun};
    want = {!m_full, m_sc, m_data, m_frame, m_busy, m_under};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL outputs t=%0t rdy/sclk/data/frame/busy/und got=%b want=%b",
               $time, got, want);
    end
    if (reset_n && underrun) ucnt++;
    if (reset_n && !prev_sc && ser_clk && busy) rx.push_back({ser_frame, ser_data});
    prev_sc = ser_clk;
  end

  task automatic step();
    @(negedge clk_in);
    #2;
  endtask

  task automatic chk(input string nm, input int g, input int w);
    total++;
    if (g != w) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, g, w);
    end
  endtask

  task automatic chk_word(input string nm, input int off,
                          input logic [DW-1:0] w, input logic par);
    logic [DW:0] e;
    logic [FLEN-1:0] wb, gb, wf, gf;
    e  = {w, par};
    wb = FLEN'(e >> (DW + 1 - FLEN));
    wf = '0;
    wf[FLEN-1] = 1'b1;
    total++;
    if (rx.size() < off + FLEN) begin
      bad++;
      $display("FAIL %s_len got=%0d want>=%0d", nm, rx.size(), off + FLEN);
    end else begin
      gb = '0;
      gf = '0;
      for (int i = 0; i < FLEN; i++) begin
        gb[FLEN-1-i] = rx[off+i][0];
        gf[FLEN-1-i] = rx[off+i][1];
      end
      if (gb !== wb || gf !== wf) begin
        bad++;
        $display("FAIL %s_bits got=%h frame=%h want=%h frame=%h", nm, gb, gf, wb, wf);
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    bit ok;
    ok = 1'b0;
    tx.tx_valid = 1'b1;
    tx.tx_data  = w;
    for (int i = 0; i < BUDGET; i++) begin
      if (tx.tx_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout word=%h got=notaccepted want=accepted", w);
    end
    step();
  endtask

  task automatic wait_under(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (ucnt >= target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL underrun_timeout got=%0d want=%0d", ucnt, target);
    end
    repeat (4) step();
  endtask

  int u0;
  int stalled;
  bit bp_ok;

  initial begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;

    // reset held across slow_clk toggles
    repeat (500) step();
    chk("rst_ready", tx.tx_ready, 1);
    chk("rst_outs", {ser_clk, ser_data, ser_frame, busy, underrun}, 0);
    reset_n = 1'b1;
    repeat (1000) step();
    chk("idle_underrun", ucnt, 0);
    chk("idle_rx", rx.size(), 0);

    // single word
    rx.delete();
    u0 = ucnt;
    send(16'hA5C3);
    tx.tx_valid = 1'b0;
    wait_under(u0 + 1);
    chk_word("single", 0, 16'hA5C3, 1'b0);
    chk("single_len", rx.size(), FLEN);
    chk("single_under", ucnt - u0, 1);
    chk("single_busy", busy, 0);

    // back-to-back frames
    rx.delete();
    u0 = ucnt;
    send(16'hFFFF);
    send(16'h0001);
    tx.tx_valid = 1'b0;
    wait_under(u0 + 1);
    chk_word("b2b0", 0, 16'hFFFF, 1'b0);
    chk_word("b2b1", FLEN, 16'h0001, 1'b1);
    chk("b2b_len", rx.size(), 2 * FLEN);
    chk("b2b_under", ucnt - u0, 1);

    // backpressure with changing data while the buffer is full
    rx.delete();
    u0 = ucnt;
    send(16'h1234);
    send(16'h5678);
    stalled = 0;
    bp_ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (tx.tx_ready) begin
        bp_ok = 1'b1;
        break;
      end
      tx.tx_data = DW'($urandom);
      stalled++;
      step();
    end
    chk("bp_reopen", int'(bp_ok), 1);
    tx.tx_data = 16'h9ABC;
    step();
    tx.tx_valid = 1'b0;
    chk("bp_stalled", int'(stalled > 100), 1);
    wait_under(u0 + 1);
    chk_word("bp0", 0, 16'h1234, 1'b1);
    chk_word("bp1", FLEN, 16'h5678, 1'b0);
    chk_word("bp2", 2 * FLEN, 16'h9ABC, 1'b1);
    chk("bp_len", rx.size(), 3 * FLEN);

    // reset after five bits of a frame
    rx.delete();
    u0 = ucnt;
    send(16'h8000);
    tx.tx_valid = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (rx.size() >= 5) break;
      step();
    end
    chk("mid_bits", rx.size(), 5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", tx.tx_ready, 1);
    chk("mid_rst_outs", {ser_clk, ser_data, ser_frame, busy, underrun}, 0);
    repeat (20) step();
    reset_n = 1'b1;
    repeat (6 * HALF) step();
    chk("mid_no_resume", rx.size(), 5);
    chk("mid_no_under", ucnt - u0, 0);
    chk("mid_busy", busy, 0);

`ifdef SER_PARITY_EN
    rx.delete();
    u0 = ucnt;
    send(16'h0007);
    tx.tx_valid = 1'b0;
    wait_under(u0 + 1);
    chk_word("par7", 0, 16'h0007, 1'b1);
    chk("par7_len", rx.size(), 17);

    rx.delete();
    u0 = ucnt;
    send(16'h0003);
    tx.tx_valid = 1'b0;
    wait_under(u0 + 1);
    chk_word("par3", 0, 16'h0003, 1'b0);
    chk("par3_len", rx.size(), 17);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slow_clk_serializer.md
Name: slow_clk_serializer

Overview:
- Downstream consumer of the 64 kHz divided clock generated from the 25 MHz system clock.
- Accepts parallel words from a valid/ready source in the clk_in domain and shifts them out MSB-first, one bit per slow-clock period, with a frame strobe on the first bit.
- Output data changes on slow-clock falling edges so the serial receiver can sample on rising edges.
- The whole block runs on clk_in; slow_clk is treated as a data input: synchronized, then edge-detected.

Parameters:
- DATA_WIDTH, 16, serial word length in bits (range 2..32).
- SYNC_STAGES, 2, synchronizer flops on slow_clk (minimum 2).

Ports:
- clk_in  input  1  system clock (25 MHz).
- reset_n  input  1  asynchronous active-low reset.
- slow_clk  input  1  divided clock from the frequency divider, treated as asynchronous data.
- tx_data  input  DATA_WIDTH  parallel word to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding buffer empty; a word is accepted when tx_valid and tx_ready are both high.
- ser_clk  output  1  registered, synchronized copy of slow_clk.
- ser_data  output  1  serial data bit.
- ser_frame  output  1  high for the full slow period of each word's first bit.
- busy  output  1  high while in SHIFT.
- underrun  output  1  one-cycle pulse when a frame ends with no word buffered.

Behaviour:
- Reset (async assert, sync deassert by the registers' own clocking):
  - tx_ready=1, ser_clk=0, ser_data=0, ser_frame=0, busy=0, underrun=0.
  - Synchronizer=0, buffer empty, bit_cnt=0, state IDLE.
- Slow-clock synchronization and edge detection:
  - slow_clk passes through SYNC_STAGES flops to give s.
  - ser_clk <= s every cycle.
  - fall = ~s & ser_clk; rise is not used.
  - fall is detected SYNC_STAGES+1 clk_in edges after the slow_clk falling transition.
- Holding buffer (1 deep):
  - tx_ready = ~buf_full.
  - On accept, the word is captured and buf_full is set on the next edge.
  - Because tx_ready=0 whenever a load from the buffer can occur, accept and load never coincide.
- State IDLE:
  - ser_data=0, ser_frame=0, busy=0.
  - On fall with buf_full: shift_reg <= buffer, buf_full <= 0, ser_data <= buffer MSB, ser_frame <= 1, bit_cnt <= DATA_WIDTH-1, go to SHIFT.
  - On fall without buf_full: no change.
- State SHIFT (busy=1), on each fall:
  - bit_cnt>0: ser_data <= next bit (MSB-first), bit_cnt--, ser_frame <= 0.
  - bit_cnt==0 and buf_full: load the next word exactly as from IDLE (back-to-back frames, no gap bit).
  - bit_cnt==0 and buffer empty: ser_data <= 0, ser_frame <= 0, underrun pulses for 1 cycle, go to IDLE.
- Timing and latency:
  - ser_data and ser_frame update on the same clk_in edge at which ser_clk falls; they are stable across the following ser_clk rising edge.
  - Latency from accept to first bit: from the first fall detected at least 1 cycle after buf_full is set, up to one slow period plus SYNC_STAGES+1 cycles.
- A word is sent as exactly DATA_WIDTH slow periods. Bit order is MSB first.
- Reset mid-frame aborts immediately: the partial word and the buffered word are discarded. There is no resume.
- slow_clk stuck (no edges): state and outputs hold; tx_ready stays 0 once the buffer is full.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - After the LSB, one extra bit period carries even parity (XOR of all DATA_WIDTH bits); a frame is DATA_WIDTH+1 periods.
  - bit_cnt is loaded with DATA_WIDTH, and frame-end/load decisions happen after the parity bit.
  - The bit counter is widened to hold DATA_WIDTH.
- Not defined: frames are exactly DATA_WIDTH periods and no parity logic is present.

Test Plan:
- Reset check: hold reset_n=0 while slow_clk toggles at 64 kHz (a slow-clock edge every 195 clk_in cycles) -> tx_ready=1 and all other outputs 0. Deassert reset_n with no tx_valid -> state stays IDLE, underrun never pulses.
- Single word: accept 16'hA5C3 -> ser_frame high for exactly 1 slow period. Sampling ser_data at ser_clk rising edges yields 1010_0101_1100_0011. Then underrun pulses 1 cycle and busy falls.
- Back-to-back: send 16'hFFFF, then 16'h0001 as soon as tx_ready returns -> 32 contiguous bits, ser_frame high on bits 0 and 16 only, no underrun.
- Backpressure: hold tx_valid=1 with changing tx_data while the buffer is full -> tx_ready=0; only the words present on accept cycles are transmitted.
- Reset mid-frame: assert reset_n=0 after 5 bits of 16'h8000 -> outputs return to reset values within the same cycle. After release, no residual bits are sent.
- SER_PARITY_EN defined: word 16'h0007 -> 17-bit frame with parity bit 1. Word 16'h0003 -> parity bit 0.
